peak_rv32_decode_stage: RTL and testbench
=========================================

# peak_rv32_decode_stage

Registered, parametrised RV32 decode pipeline stage between fetch and execute. Accepts fetched instruction words with their PC over a valid/ready handshake and produces decoded register numbers, immediate, an instruction class and an illegal flag one cycle later. A 2-entry skid buffer keeps full throughput under backpressure, and a flush input supports redirects. Compile-time options cover M, Zicsr and RV32E, and a saturating counter tracks decoded and illegal instructions.

## Interface
- PC_WIDTH, 32, width of carried program counter
- ENABLE_M, 1, 1: MUL/DIV/REM decode as class MULDIV; 0: they are illegal
- ENABLE_ZICSR, 1, 1: CSRRW/S/C(I) legal; 0: illegal (ECALL/EBREAK/MRET stay legal)
- RV32E, 0, 1: any used rd/rs1/rs2 field with bit 4 set is illegal
- CNT_WIDTH, 16, width of statistics counters
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- IN_VALID  in  1  fetch word valid
- IN_READY  out  1  stage can accept; registered, equals "skid slot empty"
- IN_INST  in  32  instruction word
- IN_PC  in  PC_WIDTH  instruction address
- FLUSH  in  1  discard all held and incoming instructions this cycle
- OUT_VALID  out  1  decoded entry valid
- OUT_READY  in  1  execute accepts entry
- OUT_PC  out  PC_WIDTH  PC of entry
- OUT_INST  out  32  raw word of entry
- OUT_RD, OUT_RS1, OUT_RS2  out  5 each  register numbers (0 where the format has no such field)
- OUT_IMM  out  32  sign-extended immediate per format (I/S/B/U/J); CSR-immediate forms: {27'b0, zimm}; else 0
- OUT_CLASS  out  4  0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 CSR, 10 SYSTEM (ECALL/EBREAK/MRET), 11 FENCE (FENCE/FENCE.I), 12 MULDIV, 15 ILLEGAL
- OUT_FUNCT3  out  3  inst[14:12] pass-through
- OUT_ALT  out  1  inst[30] for SUB/SRA/SRAI, else 0
- OUT_ILL  out  1  illegal; OUT_CLASS=15 when set
- CNT_DECODED, CNT_ILLEGAL  out  CNT_WIDTH  saturating counts of entries consumed at output

## Operation
- Decode is combinational on IN_INST; results are registered into the main output register (OREG) or the skid register (SREG).
- Legality is exact RV32I: opcode, funct3 and funct7 must match (shift-imm funct7 0000000/0100000 only; SYSTEM funct3=000 only imm 0x000/0x001/0x302 with rd=rs1=0).
- For CSR-immediate forms, OUT_RS1=0. For ALU_I shifts, OUT_IMM={27'b0, shamt}.
- Illegal entries are not dropped: they flow as class 15 with RD/RS1/RS2=0 and IMM=0 so execute can raise the trap.
- Input accept: IN_VALID & IN_READY & ~FLUSH.
  - Load OREG if OREG is empty or being consumed (OUT_READY) in the same cycle.
  - Otherwise load SREG, and IN_READY drops next cycle.
- Output consume: OUT_VALID & OUT_READY. SREG moves to OREG on consume; IN_READY rises the cycle after SREG empties.
- FLUSH: next cycle OREG and SREG are empty, OUT_VALID=0, IN_READY=1. A consume in the flush cycle still counts. An input presented in the flush cycle is discarded.
- Counters increment on consume (CNT_ILLEGAL also requires OUT_ILL). They saturate at all-ones and are cleared only by RST.

## Timing
- Reset values: OUT_VALID=0, IN_READY=1, all data outputs 0, counters 0. Inputs are ignored while RST=1.
- Latency: accept at cycle N gives OUT_VALID at N+1 when OREG is free.
- Throughput: 1/cycle with OUT_READY held high.
- OUT_* are stable while OUT_VALID & ~OUT_READY.
- Order is strictly preserved; at most 2 entries are held.
- Simultaneous accept, consume and full SREG cannot occur because IN_READY=0 while SREG is full.
- RST mid-stream drops all entries with no counter update.

## Test plan
- Reset then stream ADDI x1,x2,-1 (0xFFF10093), OUT_READY=1 → next cycle OUT_CLASS=1, RD=1, RS1=2, RS2=0, IMM=0xFFFFFFFF, CNT_DECODED=1.
- BEQ with imm -4 (0xFE000EE3), JAL x1,+2048 (0x001000EF), LUI x5,0x12345 (0x123452B7) back-to-back → IMM 0xFFFFFFFC / 0x00000800 / 0x12345000, classes 4/5/7, one per cycle.
- OUT_READY low for 3 cycles while feeding 3 words → 2 held, IN_READY=0 from the cycle after the 2nd accept, 3rd word waits; release → all 3 appear in order, no loss or duplication.
- FLUSH with both slots full and IN_VALID=1 → next cycle OUT_VALID=0, IN_READY=1, flushed words never appear.
- ENABLE_M=0: MUL x3,x1,x2 (0x022081B3) → OUT_ILL=1, class 15, CNT_ILLEGAL=1. With ENABLE_M=1 → class 12, no illegal. RV32E=1: ADD x16,x0,x0 → illegal.
- CNT_WIDTH=2, 5 consumes → CNT_DECODED holds at 3. CSRRWI x0,mstatus,5 (0x3002D073) → class 9, RS1=0, IMM=5.

Source files
------------

// File: rtl/peak_rv32_decode_stage.sv
// RV32 decode pipeline stage: combinational decode of the fetched word into a
// registered output slot, backed by one skid slot so backpressure costs no bubbles.
module peak_rv32_decode_stage #(
  parameter int PC_WIDTH     = 32,
  parameter int ENABLE_M     = 1,
  parameter int ENABLE_ZICSR = 1,
  parameter int RV32E        = 0,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [PC_WIDTH-1:0]  in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_WIDTH-1:0]  out_pc,
  output logic [31:0]          out_inst,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [31:0]          out_imm,
  output logic [3:0]           out_class,
  output logic [2:0]           out_funct3,
  output logic                 out_alt,
  output logic                 out_ill,
  output logic [CNT_WIDTH-1:0] cnt_decoded,
  output logic [CNT_WIDTH-1:0] cnt_illegal
);

  localparam logic [3:0] CLS_ALU_R  = 4'd0,  CLS_ALU_I = 4'd1,  CLS_LOAD  = 4'd2,
                         CLS_STORE  = 4'd3,  CLS_BRANCH = 4'd4, CLS_JAL   = 4'd5,
                         CLS_JALR   = 4'd6,  CLS_LUI   = 4'd7,  CLS_AUIPC = 4'd8,
                         CLS_CSR    = 4'd9,  CLS_SYSTEM = 4'd10, CLS_FENCE = 4'd11,
                         CLS_MULDIV = 4'd12, CLS_ILL   = 4'd15;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         inst;
    logic [3:0]          cls;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [31:0]         imm;
    logic                alt;
    logic                ill;
  } entry_t;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [3:0]  raw_cls;
  logic [31:0] raw_imm;
  logic        raw_alt, use_rd, use_rs1, use_rs2, rv32e_bad, dec_ill;
  entry_t      dec_entry;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7     = in_inst[31:25];
  assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u  = {in_inst[31:12], 12'b0};
  assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  always_comb begin
    raw_cls = CLS_ILL;
    raw_imm = 32'd0;
    raw_alt = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      7'b0110111: begin raw_cls = CLS_LUI;   use_rd = 1'b1; raw_imm = imm_u; end
      7'b0010111: begin raw_cls = CLS_AUIPC; use_rd = 1'b1; raw_imm = imm_u; end
      7'b1101111: begin raw_cls = CLS_JAL;   use_rd = 1'b1; raw_imm = imm_j; end
      7'b1100111: if (f3 == 3'b000) begin
        raw_cls = CLS_JALR; use_rd = 1'b1; use_rs1 = 1'b1; raw_imm = imm_i;
      end
      7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) begin
        raw_cls = CLS_BRANCH; use_rs1 = 1'b1; use_rs2 = 1'b1; raw_imm = imm_b;
      end
      7'b0000011: if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
        raw_cls = CLS_LOAD; use_rd = 1'b1; use_rs1 = 1'b1; raw_imm = imm_i;
      end
      7'b0100011: if (!f3[2] && f3 != 3'b011) begin
        raw_cls = CLS_STORE; use_rs1 = 1'b1; use_rs2 = 1'b1; raw_imm = imm_s;
      end
      7'b0010011: begin
        // Shift-immediates carry only a 5-bit shamt; funct7 must be a real shift encoding.
        if (f3 == 3'b001 || f3 == 3'b101) begin
          if (f7 == 7'b0000000 || (f3 == 3'b101 && f7 == 7'b0100000)) begin
            raw_cls = CLS_ALU_I; use_rd = 1'b1; use_rs1 = 1'b1;
            raw_imm = {27'd0, in_inst[24:20]};
            raw_alt = in_inst[30];
          end
        end else begin
          raw_cls = CLS_ALU_I; use_rd = 1'b1; use_rs1 = 1'b1; raw_imm = imm_i;
        end
      end
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          raw_cls = CLS_ALU_R;
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          raw_cls = CLS_ALU_R; raw_alt = 1'b1;
        end else if (f7 == 7'b0000001 && ENABLE_M != 0) begin
          raw_cls = CLS_MULDIV;
        end
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b0001111: if (f3 == 3'b000 || f3 == 3'b001) raw_cls = CLS_FENCE;
      7'b1110011: begin
        if (f3 == 3'b000) begin
          if (in_inst[11:7] == 5'd0 && in_inst[19:15] == 5'd0 &&
              (in_inst[31:20] == 12'h000 || in_inst[31:20] == 12'h001 ||
               in_inst[31:20] == 12'h302))
            raw_cls = CLS_SYSTEM;
        end else if (f3 != 3'b100 && ENABLE_ZICSR != 0) begin
          raw_cls = CLS_CSR; use_rd = 1'b1;
          if (f3[2]) raw_imm = {27'd0, in_inst[19:15]};
          else       use_rs1 = 1'b1;
        end
      end
      default: raw_cls = CLS_ILL;
    endcase
  end

  assign rv32e_bad = (RV32E != 0) &&
                     ((use_rd && in_inst[11]) || (use_rs1 && in_inst[19]) || (use_rs2 && in_inst[24]));
  assign dec_ill   = (raw_cls == CLS_ILL) || rv32e_bad;

  // Illegal words still flow so execute can trap, but carry no operands.
  always_comb begin
    dec_entry      = '0;
    dec_entry.pc   = in_pc;
    dec_entry.inst = in_inst;
    dec_entry.ill  = dec_ill;
    dec_entry.cls  = dec_ill ? CLS_ILL : raw_cls;
    if (!dec_ill) begin
      dec_entry.rd  = use_rd  ? in_inst[11:7]  : 5'd0;
      dec_entry.rs1 = use_rs1 ? in_inst[19:15] : 5'd0;
      dec_entry.rs2 = use_rs2 ? in_inst[24:20] : 5'd0;
      dec_entry.imm = raw_imm;
      dec_entry.alt = raw_alt;
    end
  end

  entry_t               oreg_reg, sreg_reg;
  logic                 oreg_valid_reg, sreg_valid_reg;
  logic [CNT_WIDTH-1:0] cnt_decoded_reg, cnt_illegal_reg;
  logic                 accept, consume;

  assign accept  = in_valid && !sreg_valid_reg && !flush;
  assign consume = oreg_valid_reg && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      oreg_reg        <= '0;
      sreg_reg        <= '0;
      oreg_valid_reg  <= 1'b0;
      sreg_valid_reg  <= 1'b0;
      cnt_decoded_reg <= '0;
      cnt_illegal_reg <= '0;
    end else begin
      if (consume && cnt_decoded_reg != '1)
        cnt_decoded_reg <= cnt_decoded_reg + CNT_WIDTH'(1);
      if (consume && oreg_reg.ill && cnt_illegal_reg != '1)
        cnt_illegal_reg <= cnt_illegal_reg + CNT_WIDTH'(1);
      if (flush) begin
        oreg_valid_reg <= 1'b0;
        sreg_valid_reg <= 1'b0;
      end else if (consume) begin
        // accept cannot coincide with a full skid slot, since in_ready is low then
        if (sreg_valid_reg) begin
          oreg_reg       <= sreg_reg;
          sreg_valid_reg <= 1'b0;
        end else if (accept) begin
          oreg_reg <= dec_entry;
        end else begin
          oreg_valid_reg <= 1'b0;
        end
      end else if (accept) begin
        if (!oreg_valid_reg) begin
          oreg_reg       <= dec_entry;
          oreg_valid_reg <= 1'b1;
        end else begin
          sreg_reg       <= dec_entry;
          sreg_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign in_ready    = !sreg_valid_reg;
  assign out_valid   = oreg_valid_reg;
  assign out_pc      = oreg_reg.pc;
  assign out_inst    = oreg_reg.inst;
  assign out_rd      = oreg_reg.rd;
  assign out_rs1     = oreg_reg.rs1;
  assign out_rs2     = oreg_reg.rs2;
  assign out_imm     = oreg_reg.imm;
  assign out_class   = oreg_reg.cls;
  assign out_funct3  = oreg_reg.inst[14:12];
  assign out_alt     = oreg_reg.alt;
  assign out_ill     = oreg_reg.ill;
  assign cnt_decoded = cnt_decoded_reg;
  assign cnt_illegal = cnt_illegal_reg;

endmodule

// File: tb/tb_peak_rv32_decode_stage.sv
// Bench for peak_rv32_decode_stage: vector table streamed through a scoreboard,
// plus stall, flush and reduced-configuration (no M, RV32E, 2-bit counter) sequences.
module tb_peak_rv32_decode_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, flush, out_valid, out_ready, out_alt, out_ill;
  logic [31:0] in_inst, in_pc, out_pc, out_inst, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [3:0]  out_class;
  logic [2:0]  out_funct3;
  logic [15:0] cnt_decoded, cnt_illegal;

  peak_rv32_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm), .out_class(out_class), .out_funct3(out_funct3),
    .out_alt(out_alt), .out_ill(out_ill), .cnt_decoded(cnt_decoded), .cnt_illegal(cnt_illegal)
  );

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_alt, b_out_ill;
  logic        b_flush = 1'b0, b_out_ready = 1'b1;
  logic [31:0] b_in_inst, b_in_pc, b_out_pc, b_out_inst, b_out_imm;
  logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
  logic [3:0]  b_out_class;
  logic [2:0]  b_out_funct3;
  logic [1:0]  b_cnt_decoded, b_cnt_illegal;

  peak_rv32_decode_stage #(.ENABLE_M(0), .RV32E(1), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst),
    .in_pc(b_in_pc), .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pc(b_out_pc), .out_inst(b_out_inst), .out_rd(b_out_rd), .out_rs1(b_out_rs1),
    .out_rs2(b_out_rs2), .out_imm(b_out_imm), .out_class(b_out_class), .out_funct3(b_out_funct3),
    .out_alt(b_out_alt), .out_ill(b_out_ill), .cnt_decoded(b_cnt_decoded), .cnt_illegal(b_cnt_illegal)
  );

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        alt;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    vec_t        v;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t mon_e;
  int   total = 0, bad = 0, pushed = 0, pushed_ill = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic [31:0] inst, input logic [3:0] cls, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                              input logic alt);
    vec_t v;
    v.inst = inst; v.cls = cls; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.alt = alt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Scoreboard side: every consumed entry must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_output: got pc %h want no entry", out_pc);
      end else begin
        mon_e = sb.pop_front();
        $display("consume pc=%h inst=%h class=%0d rd=%0d rs1=%0d rs2=%0d imm=%h ill=%0b",
                 out_pc, out_inst, out_class, out_rd, out_rs1, out_rs2, out_imm, out_ill);
        chk("pc", out_pc, mon_e.pc);
        chk("inst", out_inst, mon_e.v.inst);
        chk("class", {28'd0, out_class}, {28'd0, mon_e.v.cls});
        chk("rd", {27'd0, out_rd}, {27'd0, mon_e.v.rd});
        chk("rs1", {27'd0, out_rs1}, {27'd0, mon_e.v.rs1});
        chk("rs2", {27'd0, out_rs2}, {27'd0, mon_e.v.rs2});
        chk("imm", out_imm, mon_e.v.imm);
        chk("alt", {31'd0, out_alt}, {31'd0, mon_e.v.alt});
        chk("ill", {31'd0, out_ill}, {31'd0, mon_e.v.cls == 4'd15});
        chk("funct3", {29'd0, out_funct3}, {29'd0, mon_e.v.inst[14:12]});
      end
    end
  end

  task automatic drive(input vec_t v, input logic [31:0] pc);
    exp_t e;
    in_valid = 1'b1;
    in_inst  = v.inst;
    in_pc    = pc;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        e.pc = pc;
        e.v  = v;
        sb.push_back(e);
        pushed++;
        if (v.cls == 4'd15) pushed_ill++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    total++;
    bad++;
    $display("FAIL accept_timeout: got in_ready=0 for 40 cycles want accept of pc %h", pc);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      if (sb.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  int   t0;
  vec_t addi;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_inst = '0; b_in_pc = '0;

    addi = mk(32'hFFF10093, 4'd1, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b0);
    vecs.push_back(mk(32'hFE000EE3, 4'd4, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0));
    vecs.push_back(mk(32'h001000EF, 4'd5, 5'd1, 5'd0, 5'd0, 32'h00000800, 1'b0));
    vecs.push_back(mk(32'h123452B7, 4'd7, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0));
    vecs.push_back(mk(32'h022081B3, 4'd12, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0));
    vecs.push_back(mk(32'h3002D073, 4'd9, 5'd0, 5'd0, 5'd0, 32'h5, 1'b0));
    vecs.push_back(mk(32'h402081B3, 4'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1));
    vecs.push_back(mk({7'h20, 5'd3, 5'd6, 3'd5, 5'd5, 7'h13}, 4'd1, 5'd5, 5'd6, 5'd0, 32'h3, 1'b1));
    vecs.push_back(mk({7'h7F, 5'd2, 5'd1, 3'd2, 5'b11000, 7'h23}, 4'd3, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 1'b0));
    vecs.push_back(mk({12'd16, 5'd8, 3'd2, 5'd7, 7'h03}, 4'd2, 5'd7, 5'd8, 5'd0, 32'd16, 1'b0));
    vecs.push_back(mk({12'd4, 5'd2, 3'd0, 5'd1, 7'h67}, 4'd6, 5'd1, 5'd2, 5'd0, 32'd4, 1'b0));
    vecs.push_back(mk({20'hFFFFF, 5'd10, 7'h17}, 4'd8, 5'd10, 5'd0, 5'd0, 32'hFFFFF000, 1'b0));
    vecs.push_back(mk(32'h00000073, 4'd10, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0));
    vecs.push_back(mk(32'h30200073, 4'd10, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0));
    vecs.push_back(mk(32'h0000100F, 4'd11, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0));
    vecs.push_back(mk({12'h300, 5'd6, 3'd1, 5'd5, 7'h73}, 4'd9, 5'd5, 5'd6, 5'd0, 32'h0, 1'b0));
    vecs.push_back(mk({7'h20, 5'd1, 5'd2, 3'd1, 5'd3, 7'h13}, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0));
    vecs.push_back(mk(32'h00200073, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0));
    vecs.push_back(mk(32'h00000000, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_imm", out_imm, 32'd0);
    chk("rst_cnt_decoded", {16'd0, cnt_decoded}, 32'd0);
    chk("rst_cnt_illegal", {16'd0, cnt_illegal}, 32'd0);

    // Single ADDI: visible the cycle after accept, counted once consumed.
    drive(addi, 32'h0000_0100);
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    chk("first_cnt_decoded", {16'd0, cnt_decoded}, 32'd1);

    t0 = cyc;
    foreach (vecs[i]) drive(vecs[i], 32'h0000_1000 + 32'(i) * 4);
    chk("stream_cycles", 32'(cyc - t0), 32'(vecs.size()));
    drain();
    chk("cnt_decoded", {16'd0, cnt_decoded}, 32'(pushed));
    chk("cnt_illegal", {16'd0, cnt_illegal}, 32'(pushed_ill));

    // Backpressure: two entries held, third waits until the stall is released.
    out_ready = 1'b0;
    drive(vecs[0], 32'h0000_2000);
    chk("bp_in_ready_1", {31'd0, in_ready}, 32'd1);
    drive(vecs[1], 32'h0000_2004);
    chk("bp_in_ready_2", {31'd0, in_ready}, 32'd0);
    fork
      drive(vecs[2], 32'h0000_2008);
      begin
        repeat (2) @(posedge clk);
        #1;
        chk("bp_hold_pc", out_pc, 32'h0000_2000);
        chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush with both slots full and a new word presented: nothing may emerge.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = vecs[3].inst; in_pc = 32'h0000_3000;
    @(posedge clk); #1;
    in_inst = vecs[4].inst; in_pc = 32'h0000_3004;
    @(posedge clk); #1;
    chk("fl_full_in_ready", {31'd0, in_ready}, 32'd0);
    in_inst = vecs[5].inst; in_pc = 32'h0000_3008; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("fl_still_empty", {31'd0, out_valid}, 32'd0);
    chk("fl_cnt_decoded", {16'd0, cnt_decoded}, 32'(pushed));
    drive(vecs[6], 32'h0000_3100);
    drain();

    // Reduced configuration: MUL illegal, x16 illegal under RV32E, 2-bit counters saturate.
    b_in_valid = 1'b1; b_in_inst = 32'h022081B3; b_in_pc = 32'h0000_4000;
    @(posedge clk); #1;
    chk("b_mul_ill", {31'd0, b_out_ill}, 32'd1);
    chk("b_mul_class", {28'd0, b_out_class}, 32'd15);
    b_in_inst = {7'h00, 5'd0, 5'd0, 3'd0, 5'd16, 7'h33}; b_in_pc = 32'h0000_4004;
    @(posedge clk); #1;
    chk("b_cnt_illegal_1", {30'd0, b_cnt_illegal}, 32'd1);
    chk("b_rv32e_ill", {31'd0, b_out_ill}, 32'd1);
    b_in_inst = 32'hFFF10093;
    @(posedge clk); #1;
    chk("b_addi_class", {28'd0, b_out_class}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b_cnt_decoded_sat", {30'd0, b_cnt_decoded}, 32'd3);
    chk("b_cnt_illegal_2", {30'd0, b_cnt_illegal}, 32'd2);
    chk("b_out_valid_idle", {31'd0, b_out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
